// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the alu and its command dispatch front end:
//   operand/opcode widths, the alu opcode map, the packed command record
//   that travels through the dispatch FIFO, and the dispatch FSM state type.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Widths of the alu OPCODE and OP1/OP2 inputs.
    localparam int OPC_W = 3;
    localparam int DAT_W = 4;

    // Opcode map understood by the alu.
    localparam logic [OPC_W-1:0] ALU_OP_ADD = 3'd0;
    localparam logic [OPC_W-1:0] ALU_OP_SUB = 3'd1;
    localparam logic [OPC_W-1:0] ALU_OP_AND = 3'd2;
    localparam logic [OPC_W-1:0] ALU_OP_OR  = 3'd3;
    localparam logic [OPC_W-1:0] ALU_OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] ALU_OP_NOT = 3'd5;
    localparam logic [OPC_W-1:0] ALU_OP_SHL = 3'd6;
    localparam logic [OPC_W-1:0] ALU_OP_SHR = 3'd7;

    // One queued command; field order matches {OPCODE, OP1, OP2}.
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [DAT_W-1:0] op1;
        logic [DAT_W-1:0] op2;
    } alu_cmd_t;

    localparam int CMD_W = $bits(alu_cmd_t);

    // Dispatch FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } dispatch_state_e;

    function automatic alu_cmd_t make_cmd(input logic [OPC_W-1:0] opcode,
                                          input logic [DAT_W-1:0] op1,
                                          input logic [DAT_W-1:0] op2);
        alu_cmd_t c;
        c.opcode = opcode;
        c.op1    = op1;
        c.op2    = op2;
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_dispatch_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_dispatch_if
//   Host command channel into the dispatch stage (valid/ready handshake).
//   master : host side, drives the command and valid, samples ready
//   slave  : dispatch side, samples the command, drives ready
//   Signals: cmd_valid, cmd_ready, cmd_opcode[OPC_W], cmd_op1[DAT_W], cmd_op2[DAT_W]
// ---------------------------------------------------------------------------
interface alu_cmd_dispatch_if;
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPC_W-1:0] cmd_opcode;
    logic [DAT_W-1:0] cmd_op1;
    logic [DAT_W-1:0] cmd_op2;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_op1,
        output cmd_op2,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_op1,
        input  cmd_op2,
        output cmd_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   DEPTH-entry FIFO of alu_cmd_t records with an occupancy counter.
//   Ports:
//     clk, rstn     clock, asynchronous active-low reset
//     push, wdata   write one record (ignored when full or flushing)
//     pop           retire the head record (ignored when empty or flushing)
//     flush         empty the FIFO and return both pointers to 0
//     rdata         current head record (valid while !empty)
//     level         occupancy, 0..DEPTH
//     full, empty   decoded from level
// ---------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  alu_cmd_t                 wdata,
    input  logic                     pop,
    input  logic                     flush,
    output alu_cmd_t                 rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    alu_cmd_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [LVL_W-1:0]     level_reg;

    logic                 do_push;
    logic                 do_pop;

    // Full/empty come from the occupancy count so that pointer equality
    // is never ambiguous.
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;

    // Flush outranks both push and pop.
    assign do_push = push && !flush && !full;
    assign do_pop  = pop  && !flush && !empty;

    // Head is read asynchronously; the consumer registers it on pop, which
    // gives the one-cycle enqueue-to-issue latency.
    assign rdata   = mem_reg[rd_ptr_reg];

    // Storage carries no reset: entries are only observed after a push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are PTR_W bits wide and wrap modulo DEPTH by overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            level_reg <= level_reg + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/alu_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// alu_cmd_dispatch
//   Issue stage in front of the alu. Host commands are buffered in a small
//   FIFO and issued onto registered OPCODE/OP1/OP2, at most one per cycle,
//   whenever the alu is not stalling.
//   Ports:
//     clk, rstn        clock, asynchronous active-low reset
//     cmd (slave)      host command channel (valid/ready + opcode/op1/op2)
//     flush            drop every queued command (synchronous)
//     alu_stall        alu cannot accept a command this cycle
//     OPCODE/OP1/OP2   registered command to the alu; hold when issue=0
//     issue            OPCODE/OP1/OP2 carry a new command this cycle
//     level            FIFO occupancy
//     issued_cnt       commands issued since reset, wrapping
//     err_ovf          sticky: host presented a command while not ready
// ---------------------------------------------------------------------------
module alu_cmd_dispatch
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    alu_cmd_dispatch_if.slave       cmd,
    input  logic                    flush,
    input  logic                    alu_stall,
    output logic [OPC_W-1:0]        OPCODE,
    output logic [DAT_W-1:0]        OP1,
    output logic [DAT_W-1:0]        OP2,
    output logic                    issue,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        issued_cnt,
    output logic                    err_ovf
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    dispatch_state_e    state_reg;
    dispatch_state_e    state_next;

    logic               rdy_en_reg;
    logic [OPC_W-1:0]   opcode_reg;
    logic [DAT_W-1:0]   op1_reg;
    logic [DAT_W-1:0]   op2_reg;
    logic               issue_reg;
    logic [CNT_W-1:0]   issued_cnt_reg;
    logic               err_ovf_reg;

    alu_cmd_t           fifo_wdata;
    alu_cmd_t           fifo_head;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_full;
    logic               fifo_empty;

    logic               cmd_ready_int;
    logic               push_req;
    logic               push_ok;
    logic               ovf_hit;
    logic               pop;
    logic [LVL_W-1:0]   lvl_after;

    // Ready is held low until the first edge after reset release so the
    // host never sees ready while the block is still coming out of reset.
    assign cmd_ready_int = rdy_en_reg && !fifo_full;
    assign cmd.cmd_ready = cmd_ready_int;

    assign push_req   = cmd.cmd_valid && cmd_ready_int;
    assign push_ok    = push_req && !flush;
    // A command offered while not ready is dropped and flagged, flush or not.
    assign ovf_hit    = cmd.cmd_valid && !cmd_ready_int;
    assign fifo_wdata = make_cmd(cmd.cmd_opcode, cmd.cmd_op1, cmd.cmd_op2);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_req),
        .wdata (fifo_wdata),
        .pop   (pop),
        .flush (flush),
        .rdata (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy after this edge, used to spot the FIFO draining.
    assign lvl_after = fifo_level + LVL_W'(push_ok) - LVL_W'(pop);

    // Next-state and pop decision. A pop is taken in any state as soon as
    // the alu is free and a command is waiting; this is what lets a command
    // written into an empty FIFO issue on the very next edge, and lets a
    // stalled stream resume on the first unstalled cycle.
    always_comb begin
        state_next = state_reg;
        pop        = !flush && !alu_stall && !fifo_empty;

        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (lvl_after == '0) begin
                        state_next = ST_IDLE;
                    end else if (alu_stall) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!alu_stall) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            rdy_en_reg     <= 1'b0;
            opcode_reg     <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            issue_reg      <= 1'b0;
            issued_cnt_reg <= '0;
            err_ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rdy_en_reg <= 1'b1;
            issue_reg  <= pop;
            // Operands only move on a pop; otherwise they keep the last
            // issued command, including across flush and stall.
            if (pop) begin
                opcode_reg     <= fifo_head.opcode;
                op1_reg        <= fifo_head.op1;
                op2_reg        <= fifo_head.op2;
                issued_cnt_reg <= issued_cnt_reg + CNT_W'(1);
            end
            if (ovf_hit) begin
                err_ovf_reg <= 1'b1;
            end
        end
    end

    assign OPCODE     = opcode_reg;
    assign OP1        = op1_reg;
    assign OP2        = op2_reg;
    assign issue      = issue_reg;
    assign level      = fifo_level;
    assign issued_cnt = issued_cnt_reg;
    assign err_ovf    = err_ovf_reg;

endmodule

// File: tb/tb_alu_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_dispatch
//   Scoreboarded bench for alu_cmd_dispatch. Accepted commands are queued
//   when driven; a negedge monitor pops and compares on every issue pulse
//   and tracks the expected issue count.
// ---------------------------------------------------------------------------
module tb_alu_cmd_dispatch;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LVL_W = 3;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               flush = 1'b0;
    logic               alu_stall = 1'b0;
    logic [OPC_W-1:0]   OPCODE;
    logic [DAT_W-1:0]   OP1;
    logic [DAT_W-1:0]   OP2;
    logic               issue;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   issued_cnt;
    logic               err_ovf;

    alu_cmd_dispatch_if cmd_if();

    alu_cmd_dispatch #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd        (cmd_if),
        .flush      (flush),
        .alu_stall  (alu_stall),
        .OPCODE     (OPCODE),
        .OP1        (OP1),
        .OP2        (OP2),
        .issue      (issue),
        .level      (level),
        .issued_cnt (issued_cnt),
        .err_ovf    (err_ovf)
    );

    always #5 clk = ~clk;

    int             total = 0;
    int             bad = 0;
    alu_cmd_t       sb_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    alu_cmd_t       last_issued = '0;

    function automatic alu_cmd_t mk(input logic [OPC_W-1:0] op,
                                    input logic [DAT_W-1:0] a,
                                    input logic [DAT_W-1:0] b);
        alu_cmd_t c;
        c.opcode = op;
        c.op1    = a;
        c.op2    = b;
        return c;
    endfunction

    // Scoreboard monitor: every issue pulse must match the oldest queued command.
    always @(negedge clk) begin
        if (rstn && issue === 1'b1) begin
            alu_cmd_t e;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue got=%h want=no issue", {OPCODE, OP1, OP2});
            end else begin
                e = sb_q.pop_front();
                if ({OPCODE, OP1, OP2} !== e) begin
                    bad++;
                    $display("FAIL issue_data got=%h want=%h", {OPCODE, OP1, OP2}, e);
                end
                last_issued = e;
                exp_cnt     = exp_cnt + 1'b1;
                total++;
                if (issued_cnt !== exp_cnt) begin
                    bad++;
                    $display("FAIL issued_cnt got=%0d want=%0d", issued_cnt, exp_cnt);
                end
                $display("issue op=%h op1=%h op2=%h cnt=%0d", OPCODE, OP1, OP2, issued_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for one edge; expect_accept is the bench's own
    // knowledge of whether the FIFO has room.
    task automatic drive_cmd(input alu_cmd_t c, input logic expect_accept);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_opcode = c.opcode;
        cmd_if.cmd_op1    = c.op1;
        cmd_if.cmd_op2    = c.op2;
        total++;
        if (cmd_if.cmd_ready !== expect_accept) begin
            bad++;
            $display("FAIL cmd_ready got=%0b want=%0b", cmd_if.cmd_ready, expect_accept);
        end
        if (expect_accept) sb_q.push_back(c);
        $display("push op=%h op1=%h op2=%h accept=%0b", c.opcode, c.op1, c.op2, expect_accept);
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        alu_stall = 1'b1;
        drive_cmd(mk(3'b101, 4'hA, 4'h5), 1'b1);
        drive_cmd(mk(3'b011, 4'h3, 4'hC), 1'b1);
        alu_stall = 1'b0;
        tick();
        total++;
        if (issue !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_issue got=%0b want=1", issue);
        end
        @(negedge clk);
        #1;
        rstn = 1'b0;
        sb_q.delete();
        exp_cnt     = '0;
        last_issued = '0;
        #1;
        total++;
        if ({OPCODE, OP1, OP2, issue, issued_cnt, err_ovf, cmd_if.cmd_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {OPCODE, OP1, OP2, issue, issued_cnt, err_ovf, cmd_if.cmd_ready});
        end
        total++;
        if (level !== 3'd0) begin
            bad++;
            $display("FAIL reset_level got=%0d want=0", level);
        end
        tick();
        #2;
        rstn = 1'b1;
        total++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%0b want=0", cmd_if.cmd_ready);
        end
        tick();
        total++;
        if (cmd_if.cmd_ready !== 1'b1 || level !== 3'd0) begin
            bad++;
            $display("FAIL ready_after_release got=%0b/%0d want=1/0", cmd_if.cmd_ready, level);
        end
    endtask

    task automatic test_single();
        alu_stall = 1'b0;
        drive_cmd(mk(3'b010, 4'b1000, 4'b0000), 1'b1);
        total++;
        if (level !== 3'd1 || issue !== 1'b0) begin
            bad++;
            $display("FAIL single_enqueued got=lvl%0d/iss%0b want=lvl1/iss0", level, issue);
        end
        tick();
        total++;
        if ({issue, OPCODE, OP1, OP2, issued_cnt} !== {1'b1, 3'b010, 4'b1000, 4'b0000, 8'd1}) begin
            bad++;
            $display("FAIL single_issue got=%b %b %b %b %0d want=1 010 1000 0000 1",
                     issue, OPCODE, OP1, OP2, issued_cnt);
        end
        tick();
        total++;
        if (issue !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL single_after got=iss%0b/lvl%0d want=iss0/lvl0", issue, level);
        end
    endtask

    task automatic test_full_overflow();
        alu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(mk(OPC_W'(i + 1), DAT_W'(i * 3), DAT_W'(15 - i)), 1'b1);
        end
        total++;
        if (level !== 3'd4 || cmd_if.cmd_ready !== 1'b0 || err_ovf !== 1'b0) begin
            bad++;
            $display("FAIL full_state got=lvl%0d rdy%0b ovf%0b want=lvl4 rdy0 ovf0",
                     level, cmd_if.cmd_ready, err_ovf);
        end
        drive_cmd(mk(3'b111, 4'hF, 4'hF), 1'b0);
        total++;
        if (err_ovf !== 1'b1 || level !== 3'd4) begin
            bad++;
            $display("FAIL overflow got=ovf%0b lvl%0d want=ovf1 lvl4", err_ovf, level);
        end
        alu_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (issue !== 1'b1) begin
                bad++;
                $display("FAIL burst_issue[%0d] got=%0b want=1", i, issue);
            end
        end
        tick();
        total++;
        if (issue !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL burst_end got=iss%0b lvl%0d want=iss0 lvl0", issue, level);
        end
    endtask

    task automatic test_stall_between();
        alu_cmd_t c[4];
        c[0] = mk(3'b000, 4'h1, 4'h2);
        c[1] = mk(3'b110, 4'h7, 4'h9);
        c[2] = mk(3'b100, 4'hB, 4'h4);
        c[3] = mk(3'b001, 4'hE, 4'h6);
        alu_stall = 1'b1;
        for (int i = 0; i < 4; i++) drive_cmd(c[i], 1'b1);
        alu_stall = 1'b0;
        tick();
        tick();
        alu_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (issue !== 1'b0 || {OPCODE, OP1, OP2} !== c[1]) begin
                bad++;
                $display("FAIL stall_hold got=iss%0b %h want=iss0 %h", issue, {OPCODE, OP1, OP2}, c[1]);
            end
        end
        alu_stall = 1'b0;
        tick();
        total++;
        if (issue !== 1'b1 || {OPCODE, OP1, OP2} !== c[2]) begin
            bad++;
            $display("FAIL stall_resume got=iss%0b %h want=iss1 %h", issue, {OPCODE, OP1, OP2}, c[2]);
        end
        tick();
        tick();
        total++;
        if (issue !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL stall_drain got=iss%0b lvl%0d want=iss0 lvl0", issue, level);
        end
    endtask

    task automatic test_flush();
        alu_cmd_t held;
        logic [CNT_W-1:0] cnt_hold;
        alu_stall = 1'b1;
        drive_cmd(mk(3'b011, 4'h5, 4'h5), 1'b1);
        drive_cmd(mk(3'b101, 4'h6, 4'h1), 1'b1);
        drive_cmd(mk(3'b111, 4'h0, 4'hD), 1'b1);
        total++;
        if (level !== 3'd3) begin
            bad++;
            $display("FAIL flush_prefill got=%0d want=3", level);
        end
        held     = last_issued;
        cnt_hold = exp_cnt;
        // Unstalled during flush: flush must win over the pop.
        alu_stall = 1'b0;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        sb_q.delete();
        total++;
        if (level !== 3'd0 || issue !== 1'b0) begin
            bad++;
            $display("FAIL flush_level got=lvl%0d iss%0b want=lvl0 iss0", level, issue);
        end
        total++;
        if ({OPCODE, OP1, OP2} !== held || issued_cnt !== cnt_hold) begin
            bad++;
            $display("FAIL flush_hold got=%h cnt%0d want=%h cnt%0d",
                     {OPCODE, OP1, OP2}, issued_cnt, held, cnt_hold);
        end
        total++;
        if (err_ovf !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_flags got=ovf%0b rdy%0b want=ovf1 rdy1", err_ovf, cmd_if.cmd_ready);
        end
        repeat (3) tick();
        total++;
        if (issue !== 1'b0 || level !== 3'd0) begin
            bad++;
            $display("FAIL flush_quiet got=iss%0b lvl%0d want=iss0 lvl0", issue, level);
        end
    endtask

    task automatic test_wrap_and_simul();
        alu_cmd_t c;
        rstn = 1'b0;
        sb_q.delete();
        exp_cnt     = '0;
        last_issued = '0;
        #3;
        rstn = 1'b1;
        tick();
        alu_stall = 1'b0;
        for (int i = 0; i < 256; i++) begin
            c = mk(OPC_W'($urandom_range(0, 7)), DAT_W'($urandom_range(0, 15)),
                   DAT_W'($urandom_range(0, 15)));
            cmd_if.cmd_valid  = 1'b1;
            cmd_if.cmd_opcode = c.opcode;
            cmd_if.cmd_op1    = c.op1;
            cmd_if.cmd_op2    = c.op2;
            total++;
            if (cmd_if.cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready[%0d] got=%0b want=1", i, cmd_if.cmd_ready);
            end
            sb_q.push_back(c);
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        tick();
        total++;
        if (issue !== 1'b1 || issued_cnt !== 8'd0) begin
            bad++;
            $display("FAIL cnt_wrap got=iss%0b cnt%0d want=iss1 cnt0", issue, issued_cnt);
        end
        tick();
        total++;
        if (sb_q.size() != 0 || level !== 3'd0) begin
            bad++;
            $display("FAIL stream_drain got=q%0d lvl%0d want=q0 lvl0", sb_q.size(), level);
        end
        alu_stall = 1'b1;
        drive_cmd(mk(3'b001, 4'h2, 4'h3), 1'b1);
        drive_cmd(mk(3'b010, 4'h4, 4'h5), 1'b1);
        total++;
        if (level !== 3'd2) begin
            bad++;
            $display("FAIL simul_prefill got=%0d want=2", level);
        end
        alu_stall = 1'b0;
        drive_cmd(mk(3'b100, 4'h6, 4'h7), 1'b1);
        total++;
        if (level !== 3'd2 || issue !== 1'b1) begin
            bad++;
            $display("FAIL simul_push_pop got=lvl%0d iss%0b want=lvl2 iss1", level, issue);
        end
        repeat (4) tick();
        total++;
        if (level !== 3'd0 || err_ovf !== 1'b0) begin
            bad++;
            $display("FAIL simul_drain got=lvl%0d ovf%0b want=lvl0 ovf0", level, err_ovf);
        end
    endtask

    initial begin
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_opcode = '0;
        cmd_if.cmd_op1    = '0;
        cmd_if.cmd_op2    = '0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        tick();

        test_reset();
        test_single();
        test_full_overflow();
        test_stall_between();
        test_flush();
        test_wrap_and_simul();

        // Bounded final drain of the scoreboard.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
